// File: rtl/game_pkg.sv
// Encodings and constants shared by the game sequencer and the score datapath.
package game_pkg;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    SONG_SELECT = 2'd1,
    GAME_PLAY   = 2'd2,
    GAME_OVER   = 2'd3
  } game_state_e;

  localparam logic [7:0] COMBO_MAX = 8'd255;
  localparam int         NUM_LANES = 2;

  // A miss breaks the combo; a beat with hits extends it; an empty beat leaves it alone.
  function automatic logic [7:0] combo_next(input logic [7:0] combo,
                                            input logic       any_hit,
                                            input logic       miss);
    if (miss)                        return 8'd0;
    else if (any_hit && combo != COMBO_MAX) return combo + 8'd1;
    else                             return combo;
  endfunction

endpackage

// File: rtl/beat_timer.sv
// Beat time base: counts 0..BEAT_DIV-1 while enabled and flags the last cycle of each beat.
module beat_timer #(
  parameter int BEAT_DIV = 12500000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic beat_end
);

  localparam int            CW   = (BEAT_DIV > 1) ? $clog2(BEAT_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(BEAT_DIV - 1);

  logic [CW-1:0] count;

  assign beat_end = en && (count == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           count <= '0;
    else if (clr)      count <= '0;
    else if (beat_end) count <= '0;
    else if (en)       count <= count + CW'(1);
  end

endmodule

// File: rtl/rhythm_game_sequencer.sv
// Game-flow controller: state machine, song select, beat judging and combo tracking.
// Optional pause input is built when RHYTHM_PAUSE_EN is defined.
module rhythm_game_sequencer
  import game_pkg::*;
#(
  parameter int NUM_SONGS      = 4,
  parameter int SONG_LEN_BEATS = 128,
  parameter int BEAT_DIV       = 12500000
) (
  input  logic                                            clk,
  input  logic                                            rst,
  input  logic                                            btn_start,
  input  logic                                            btn_next,
`ifdef RHYTHM_PAUSE_EN
  input  logic                                            btn_pause,
`endif
  input  logic [NUM_LANES-1:0]                            lane_hit,
  input  logic [NUM_LANES-1:0]                            chart_notes,
  output logic [1:0]                                      game_state,
  output logic [((NUM_SONGS > 1) ? $clog2(NUM_SONGS) : 1)-1:0] song_id,
  output logic [7:0]                                      beat_idx,
  output logic [NUM_LANES-1:0]                            inp,
  output logic                                            inp_valid,
  output logic [7:0]                                      combo,
  output logic [7:0]                                      max_combo,
  output logic                                            score_clear
);

  localparam int SW = (NUM_SONGS > 1) ? $clog2(NUM_SONGS) : 1;

  game_state_e          state, state_nx;
  logic                 in_play, enter_play, run, beat_end, last_beat, miss;
  logic [NUM_LANES-1:0] hit_latch, lanes_seen, hits;
  logic [7:0]           combo_nx;

  assign game_state = state;
  assign in_play    = (state == GAME_PLAY);
  assign enter_play = (state == SONG_SELECT) && btn_start;
  assign last_beat  = (beat_idx == 8'(SONG_LEN_BEATS - 1));

`ifdef RHYTHM_PAUSE_EN
  logic paused;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                    paused <= 1'b0;
    else if (!in_play || state_nx != GAME_PLAY) paused <= 1'b0;
    else if (btn_pause)                         paused <= ~paused;
  end

  assign run = in_play && !paused;
`else
  assign run = in_play;
`endif

  beat_timer #(.BEAT_DIV(BEAT_DIV)) u_beat_timer (
    .clk      (clk),
    .rst      (rst),
    .clr      (enter_play),
    .en       (run),
    .beat_end (beat_end)
  );

  // A press in the beat-end cycle itself still belongs to the closing beat.
  assign lanes_seen = hit_latch | lane_hit;
  assign hits       = lanes_seen & chart_notes;
  assign miss       = |(chart_notes & ~lanes_seen);
  assign combo_nx   = combo_next(combo, |hits, miss);

  always_comb begin
    // NOTE: default first so every path assigns state_nx and no latch is inferred.
    state_nx = state;
    unique case (state)
      IDLE:        if (btn_start) state_nx = SONG_SELECT;
      SONG_SELECT: if (btn_start) state_nx = GAME_PLAY;
      GAME_PLAY:   if (beat_end && last_beat) state_nx = GAME_OVER;
      GAME_OVER:   if (btn_start) state_nx = IDLE;
      default:     state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: non-blocking so every register samples pre-edge values regardless of statement order.
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      song_id     <= '0;
      beat_idx    <= '0;
      inp         <= '0;
      inp_valid   <= 1'b0;
      combo       <= '0;
      max_combo   <= '0;
      score_clear <= 1'b0;
      hit_latch   <= '0;
    end else begin
      score_clear <= enter_play;
      inp_valid   <= beat_end;

      // Start wins over next when both arrive together.
      if (state == SONG_SELECT && btn_next && !btn_start)
        song_id <= (song_id == SW'(NUM_SONGS - 1)) ? '0 : song_id + SW'(1);

      if (enter_play) begin
        beat_idx  <= '0;
        combo     <= '0;
        max_combo <= '0;
        hit_latch <= '0;
      end else if (run) begin
        if (beat_end) begin
          hit_latch <= '0;
          inp       <= hits;
          combo     <= combo_nx;
          if (combo_nx > max_combo) max_combo <= combo_nx;
          if (!last_beat)           beat_idx  <= beat_idx + 8'd1;
        end else begin
          hit_latch <= lanes_seen;
        end
      end
    end
  end

endmodule

// File: tb/tb_rhythm_game_sequencer.sv
// Self-checking bench: directed scenarios plus random songs against a cycle-level game model.
module tb_rhythm_game_sequencer;

  localparam int NS  = 4;
  localparam int LEN = 4;
  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_start = 1'b0;
  logic       btn_next  = 1'b0;
  logic [1:0] lane_hit    = 2'b00;
  logic [1:0] chart_notes = 2'b00;
`ifdef RHYTHM_PAUSE_EN
  logic       btn_pause = 1'b0;
`endif

  logic [1:0] game_state;
  logic [1:0] song_id;
  logic [7:0] beat_idx;
  logic [1:0] inp;
  logic       inp_valid;
  logic [7:0] combo;
  logic [7:0] max_combo;
  logic       score_clear;

  rhythm_game_sequencer #(
    .NUM_SONGS(NS), .SONG_LEN_BEATS(LEN), .BEAT_DIV(DIV)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_start   (btn_start),
    .btn_next    (btn_next),
`ifdef RHYTHM_PAUSE_EN
    .btn_pause   (btn_pause),
`endif
    .lane_hit    (lane_hit),
    .chart_notes (chart_notes),
    .game_state  (game_state),
    .song_id     (song_id),
    .beat_idx    (beat_idx),
    .inp         (inp),
    .inp_valid   (inp_valid),
    .combo       (combo),
    .max_combo   (max_combo),
    .score_clear (score_clear)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int clear_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: play time is tracked as a cycle count since entry, beats close on
  // every DIV-th cycle, and hits are accumulated per beat as a plain lane set.
  int         m_state, m_song, m_beat, m_cyc, m_combo, m_max;
  logic [1:0] m_acc, m_inp;
  logic       m_valid, m_clear;

  always @(posedge clk or posedge rst) begin
    logic [1:0] seen;
    if (rst) begin
      m_state = 0; m_song = 0; m_beat = 0; m_cyc = 0; m_combo = 0; m_max = 0;
      m_acc = 0; m_inp = 0; m_valid = 0; m_clear = 0;
    end else begin
      m_valid = 0;
      m_clear = 0;
      case (m_state)
        0: if (btn_start) m_state = 1;
        1: begin
          if (btn_start) begin
            m_state = 2; m_clear = 1; m_cyc = 0; m_beat = 0;
            m_combo = 0; m_max = 0; m_acc = 0;
          end else if (btn_next) begin
            m_song = (m_song + 1) % NS;
          end
        end
        2: begin
          seen = m_acc | lane_hit;
          if (m_cyc % DIV == DIV - 1) begin
            m_valid = 1;
            m_inp   = seen & chart_notes;
            if ((chart_notes & ~seen) != 2'b00) m_combo = 0;
            else if (m_inp != 2'b00)            m_combo = (m_combo < 255) ? m_combo + 1 : 255;
            if (m_combo > m_max) m_max = m_combo;
            if (m_beat == LEN - 1) m_state = 3;
            else                   m_beat++;
            m_acc = 0;
          end else begin
            m_acc = seen;
          end
          m_cyc++;
        end
        default: if (btn_start) m_state = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (score_clear) clear_cnt++;
    check("game_state",  game_state,  m_state);
    check("song_id",     song_id,     m_song);
    check("beat_idx",    beat_idx,    m_beat);
    check("inp",         inp,         m_inp);
    check("inp_valid",   inp_valid,   m_valid);
    check("combo",       combo,       m_combo);
    check("max_combo",   max_combo,   m_max);
    check("score_clear", score_clear, m_clear);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic s, input logic n);
    btn_start = s;
    btn_next  = n;
    tick();
    btn_start = 1'b0;
    btn_next  = 1'b0;
  endtask

  task automatic play_beat(input logic [1:0] chart, input logic [1:0] hits, input int at);
    for (int c = 0; c < DIV; c++) begin
      chart_notes = chart;
      lane_hit    = (c == at) ? hits : 2'b00;
      tick();
    end
    lane_hit = 2'b00;
  endtask

  task automatic expect_strobe(input string name, input logic [1:0] exp_inp, input int exp_combo);
    check({name, "_valid"}, inp_valid, 1);
    check({name, "_inp"},   inp,       exp_inp);
    check({name, "_combo"}, combo,     exp_combo);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("rst_state", game_state, 0);
    check("rst_song",  song_id,    0);
    check("rst_combo", combo,      0);
    check("rst_valid", inp_valid,  0);

    // Song select, then start together with next: start wins.
    pulse(1'b1, 1'b0);
    check("to_select", game_state, 1);
    repeat (3) pulse(1'b0, 1'b1);
    check("song_after_3_next", song_id, 3);
    pulse(1'b1, 1'b1);
    check("start_wins_song", song_id, 3);
    check("start_wins_state", game_state, 2);
    check("clear_first_cycle", score_clear, 1);

    // Clean song; the last beat's hit lands in the beat-end cycle.
    play_beat(2'b11, 2'b11, 1); expect_strobe("s1b0", 2'b11, 1);
    play_beat(2'b01, 2'b01, 2); expect_strobe("s1b1", 2'b01, 2);
    play_beat(2'b10, 2'b10, 0); expect_strobe("s1b2", 2'b10, 3);
    play_beat(2'b11, 2'b11, 3); expect_strobe("s1b3", 2'b11, 4);
    check("s1_game_over", game_state, 3);
    check("s1_max_combo", max_combo, 4);
    check("s1_clear_once", clear_cnt, 1);

    pulse(1'b1, 1'b0);
    check("over_to_idle", game_state, 0);
    check("song_retained", song_id, 3);
    pulse(1'b1, 1'b0);
    pulse(1'b1, 1'b0);

    // Beat-end hit, then a partial hit on a two-note beat.
    play_beat(2'b11, 2'b11, 0); expect_strobe("s2b0", 2'b11, 1);
    play_beat(2'b01, 2'b01, 3); expect_strobe("s2b1_endhit", 2'b01, 2);
    play_beat(2'b11, 2'b01, 1); expect_strobe("s2b2_miss", 2'b01, 0);
    check("s2_max_held", max_combo, 2);
    play_beat(2'b00, 2'b10, 2); expect_strobe("s2b3_empty", 2'b00, 0);

    repeat (3) pulse(1'b1, 1'b0);

    // Extra press on an empty beat, then reset in the middle of beat 2.
    play_beat(2'b11, 2'b11, 1); expect_strobe("s3b0", 2'b11, 1);
    play_beat(2'b00, 2'b10, 1); expect_strobe("s3b1_extra", 2'b00, 1);
    chart_notes = 2'b11;
    lane_hit    = 2'b01;
    tick();
    lane_hit = 2'b00;
    tick();
    rst = 1'b1;
    #1;
    check("midrst_state", game_state, 0);
    check("midrst_beat",  beat_idx,   0);
    check("midrst_combo", combo,      0);
    check("midrst_max",   max_combo,  0);
    tick();
    tick();
    check("midrst_no_valid", inp_valid, 0);
    rst = 1'b0;
    tick();

    // Random songs with random selections, charts, presses and ignored buttons.
    for (int g = 0; g < 8; g++) begin
      pulse(1'b1, 1'b0);
      repeat ($urandom_range(0, 5)) pulse(1'b0, 1'b1);
      pulse(1'b1, 1'($urandom_range(0, 1)));
      for (int cyc = 0; cyc < LEN * DIV + 8 && game_state != 2'd3; cyc++) begin
        if (cyc % DIV == 0) chart_notes = 2'($urandom_range(0, 3));
        lane_hit  = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
        btn_next  = 1'($urandom_range(0, 1));
        btn_start = ($urandom_range(0, 7) == 0);
        tick();
      end
      lane_hit  = 2'b00;
      btn_next  = 1'b0;
      btn_start = 1'b0;
      check("rand_game_over", game_state, 3);
      tick();
      pulse(1'b1, 1'b0);
    end

    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

endmodule
